// File: rtl/la_capture_ctrl.sv
// la_capture_ctrl
// Logic-analyser capture controller. It samples the probe bus on each clken
// strobe and writes every sample into a circular sample RAM. A record holds a
// programmable number of pre-trigger samples. The trigger can be a level, an
// edge, a masked pattern or immediate. A capture runs once per arm, or re-arms
// by itself after a holdoff period.
module la_capture_ctrl #(
    parameter int CH_W    = 8,
    parameter int ADDR_W  = 15,
    parameter int HOLD_W  = 24,
    parameter int HOLDOFF = 2_499_999
) (
    input  logic                    clk_50M,
    input  logic                    rst,
    input  logic                    clken,
    input  logic                    arm,
    input  logic                    abort,
    input  logic                    continuous,
    input  logic [2:0]              mode_sel,
    input  logic [$clog2(CH_W)-1:0] channel_sel,
    input  logic [CH_W-1:0]         pattern,
    input  logic [CH_W-1:0]         pat_mask,
    input  logic [ADDR_W-1:0]       pre_len,
    input  logic [CH_W-1:0]         data_in,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [CH_W-1:0]         wr_data,
    output logic                    wren,
    output logic [ADDR_W-1:0]       start_addr,
    output logic [ADDR_W-1:0]       trig_addr,
    output logic                    busy,
    output logic                    done
);

    // DEPTH as a counter-width constant; the write counter must reach DEPTH itself
    localparam logic [ADDR_W:0]   DEPTH_V   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_WAIT_TRIG,
        S_POST,
        S_DONE,
        S_HOLDOFF
    } state_t;

    state_t              state;
    logic [CH_W-1:0]     d1;
    logic [CH_W-1:0]     d2;
    logic [ADDR_W-1:0]   p_len;     // pre-trigger length latched at arm
    logic [ADDR_W:0]     cnt;       // writes in PREFILL, or writes since trigger in POST
    logic [HOLD_W-1:0]   hold_cnt;

    logic                trig;
    logic                ch_ok;
    logic                ch_cur;
    logic                ch_prv;
    logic                sampling;
    logic                last_wr;
    logic                wr_go;
    logic                rearm;
    logic [ADDR_W:0]     cnt_inc;
    logic [ADDR_W:0]     post_len;

    // Trigger term on the two most recent samples, valid in the write cycle
    always_comb begin
        ch_ok  = (int'(channel_sel) < CH_W);
        ch_cur = 1'b0;
        ch_prv = 1'b0;
        if (ch_ok) begin
            ch_cur = d1[channel_sel];
            ch_prv = d2[channel_sel];
        end
        case (mode_sel)
            3'd0:    trig = ch_ok & ~ch_cur;
            3'd1:    trig = ch_ok & ch_cur;
            3'd2:    trig = ch_ok & ch_cur & ~ch_prv;
            3'd3:    trig = ch_ok & ~ch_cur & ch_prv;
            3'd4:    trig = ch_ok & (ch_cur ^ ch_prv);
            3'd5:    trig = ~|((d1 ^ pattern) & pat_mask);
            default: trig = 1'b1;
        endcase
    end

    // Write qualification: the write that completes a record (or an abort)
    // suppresses a sample that arrives on the same edge, so DONE never writes
    always_comb begin
        sampling = (state == S_PREFILL) || (state == S_WAIT_TRIG) || (state == S_POST);
        cnt_inc  = cnt + 1'b1;
        post_len = DEPTH_V - {1'b0, p_len};
        last_wr  = wren && (((state == S_POST) && (cnt_inc == post_len)) ||
                            ((state == S_WAIT_TRIG) && trig && (&p_len)));
        wr_go    = clken && sampling && !abort && !last_wr;
        rearm    = ((state == S_IDLE) && arm) ||
                   ((state == S_DONE) && !continuous && arm) ||
                   ((state == S_HOLDOFF) && continuous && (hold_cnt == HOLD_LAST));
    end

    // Sample pipe and RAM write port; address advances after each write cycle
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            d1      <= '0;
            d2      <= '0;
            wren    <= 1'b0;
            wr_data <= '0;
            wr_addr <= '0;
        end else begin
            if (clken) begin
                d1 <= data_in;
                d2 <= d1;
            end
            wren <= wr_go;
            if (wr_go) begin
                wr_data <= data_in;
            end
            if (wren) begin
                wr_addr <= wr_addr + 1'b1;
            end
        end
    end

    // Capture FSM; abort overrides every transition, arm is honoured only
    // from IDLE or a single-shot DONE
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            p_len      <= '0;
            cnt        <= '0;
            hold_cnt   <= '0;
            start_addr <= '0;
            trig_addr  <= '0;
        end else if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (rearm) begin
            // pre_len spans 0..DEPTH-1, so the latched length needs no clamp
            p_len <= pre_len;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= (pre_len == '0) ? S_WAIT_TRIG : S_PREFILL;
        end else begin
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
                S_PREFILL: begin
                    // trigger is deliberately ignored here, including the last prefill write
                    if (wren) begin
                        if (cnt_inc == {1'b0, p_len}) begin
                            cnt   <= '0;
                            state <= S_WAIT_TRIG;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                S_WAIT_TRIG: begin
                    if (wren && trig) begin
                        trig_addr  <= wr_addr;
                        start_addr <= wr_addr - p_len;
                        cnt        <= {{ADDR_W{1'b0}}, 1'b1};
                        if (&p_len) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (wren) begin
                        if (cnt_inc == post_len) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                S_DONE: begin
                    if (continuous) begin
                        hold_cnt <= '0;
                        state    <= S_HOLDOFF;
                    end
                end
                S_HOLDOFF: begin
                    if (!continuous) begin
                        state <= S_DONE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// tb_la_capture_ctrl
// Directed and randomized captures against a record-level reference model:
// for a sample sequence the model finds the trigger sample and derives the
// write count, trigger/start addresses and the final RAM record.
module tb_la_capture_ctrl;

    localparam int CH_W    = 8;
    localparam int ADDR_W  = 4;
    localparam int HOLD_W  = 8;
    localparam int HOLDOFF = 7;
    localparam int DEPTH   = 16;

    logic              clk_50M = 1'b0;
    logic              rst = 1'b1;
    logic              clken = 1'b0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic              continuous = 1'b0;
    logic [2:0]        mode_sel = '0;
    logic [2:0]        channel_sel = '0;
    logic [CH_W-1:0]   pattern = '0;
    logic [CH_W-1:0]   pat_mask = '0;
    logic [ADDR_W-1:0] pre_len = '0;
    logic [CH_W-1:0]   data_in = '0;
    logic [ADDR_W-1:0] wr_addr;
    logic [CH_W-1:0]   wr_data;
    logic              wren;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] trig_addr;
    logic              busy;
    logic              done;

    la_capture_ctrl #(
        .CH_W(CH_W), .ADDR_W(ADDR_W), .HOLD_W(HOLD_W), .HOLDOFF(HOLDOFF)
    ) dut (
        .clk_50M(clk_50M), .rst(rst), .clken(clken), .arm(arm), .abort(abort),
        .continuous(continuous), .mode_sel(mode_sel), .channel_sel(channel_sel),
        .pattern(pattern), .pat_mask(pat_mask), .pre_len(pre_len), .data_in(data_in),
        .wr_addr(wr_addr), .wr_data(wr_data), .wren(wren), .start_addr(start_addr),
        .trig_addr(trig_addr), .busy(busy), .done(done)
    );

    always #10 clk_50M = ~clk_50M;

    int checks = 0;
    int failures = 0;

    logic [7:0] seq [64];
    logic [7:0] mem [16];
    int         nwr = 0;
    logic [7:0] last_smp = '0;
    int         arm_at = -1;

    int exp_wa = 0;
    int exp_trig = 0;
    int exp_start = 0;
    int exp_writes = 0;
    int exp_k = -1;
    int exp_p = 0;
    bit exp_done = 0;

    // RAM image built from observed write cycles
    always @(negedge clk_50M) begin
        if (wren) begin
            mem[wr_addr] = wr_data;
            nwr = nwr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Trigger rule applied to a sample and its predecessor
    function automatic bit term(input logic [7:0] cur, input logic [7:0] prv);
        int ch;
        ch = int'(channel_sel);
        case (mode_sel)
            3'd0:    return !cur[ch];
            3'd1:    return cur[ch];
            3'd2:    return cur[ch] && !prv[ch];
            3'd3:    return !cur[ch] && prv[ch];
            3'd4:    return cur[ch] != prv[ch];
            3'd5:    return ((cur ^ pattern) & pat_mask) == 8'h00;
            default: return 1'b1;
        endcase
    endfunction

    // Record-level model: trigger is the first sample at index >= P that
    // satisfies the rule; the record needs DEPTH-P samples from the trigger on
    task automatic model_run(input int p, input int n);
        logic [7:0] prv;
        int total;
        prv   = last_smp;
        exp_k = -1;
        exp_p = p;
        for (int k = 0; k < n; k++) begin
            if (k >= p && exp_k < 0 && term(seq[k], prv)) exp_k = k;
            prv = seq[k];
        end
        total      = (exp_k < 0) ? 1000 : exp_k + DEPTH - p;
        exp_done   = (exp_k >= 0) && (total <= n);
        exp_writes = exp_done ? total : n;
        if (exp_k >= 0) begin
            exp_trig  = (exp_wa + exp_k) % DEPTH;
            exp_start = (exp_trig - p + DEPTH) % DEPTH;
        end
    endtask

    task automatic drive_seq(input int n);
        nwr = 0;
        for (int i = 0; i < n; i++) begin
            data_in = seq[i];
            clken   = 1'b1;
            tick();
            clken   = 1'b0;
            arm     = (i == arm_at);
            tick();
            arm      = 1'b0;
            last_smp = seq[i];
        end
    endtask

    task automatic check_run(input string name);
        int mism;
        check({name, "_nwr"}, nwr, exp_writes);
        check({name, "_busy"}, busy, !exp_done);
        check({name, "_done"}, done, exp_done);
        check({name, "_trig"}, trig_addr, exp_trig);
        check({name, "_start"}, start_addr, exp_start);
        exp_wa = (exp_wa + exp_writes) % DEPTH;
        check({name, "_wa"}, wr_addr, exp_wa);
        if (exp_done) begin
            mism = 0;
            for (int i = 0; i < DEPTH; i++)
                if (mem[(exp_start + i) % DEPTH] !== seq[exp_k - exp_p + i]) mism++;
            check({name, "_record"}, mism, 0);
        end
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("rst_wren", wren, 0);
        check("rst_wa", wr_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_trig", trig_addr, 0);
        rst = 1'b0;
        tick();

        // rising edge on channel 0 at the 10th sample, 4 pre-trigger samples
        mode_sel = 3'd2; channel_sel = 3'd0; pre_len = 4'd4;
        for (int i = 0; i < 24; i++) seq[i] = (i < 9) ? 8'h00 : 8'h01;
        model_run(4, 24);
        pulse_arm();
        drive_seq(24);
        tick();
        check_run("t1");

        // maximum pre-trigger length with immediate trigger; arm while busy ignored
        mode_sel = 3'd6; pre_len = 4'd15; arm_at = 5;
        for (int i = 0; i < 18; i++) seq[i] = 8'($urandom);
        model_run(15, 18);
        pulse_arm();
        drive_seq(18);
        arm_at = -1;
        tick();
        check_run("t2");

        // masked pattern: 0x3C must not match, 0xA0 must
        mode_sel = 3'd5; pattern = 8'hA5; pat_mask = 8'hF0; pre_len = 4'd2;
        for (int i = 0; i < 22; i++) seq[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            seq[i] = 8'h00;
            seq[i + 3] = 8'h3C;
        end
        seq[6] = 8'hA0;
        model_run(2, 22);
        pulse_arm();
        drive_seq(22);
        tick();
        check_run("t3");

        // abort in POST: a sample strobe in the abort cycle is not written
        mode_sel = 3'd6; pre_len = 4'd2;
        for (int i = 0; i < 5; i++) seq[i] = 8'($urandom);
        model_run(2, 5);
        pulse_arm();
        drive_seq(5);
        check_run("t5");
        data_in = 8'h5A; clken = 1'b1; abort = 1'b1;
        tick();
        clken = 1'b0; abort = 1'b0; last_smp = 8'h5A;
        check("abort_wren", wren, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        tick();
        check("abort_nwr", nwr, exp_writes);
        check("abort_trig", trig_addr, exp_trig);

        // continuous mode: holdoff gap, then a new record from the current address
        continuous = 1'b1; mode_sel = 3'd6; pre_len = 4'd3;
        for (int i = 0; i < 16; i++) seq[i] = 8'($urandom);
        model_run(3, 16);
        pulse_arm();
        drive_seq(16);
        check_run("c1");
        pre_len = 4'd5;
        for (int i = 1; i <= 8; i++) begin
            arm = (i == 4);
            tick();
            arm = 1'b0;
            check("hold_done", done, 1);
            check("hold_busy", busy, 0);
        end
        tick();
        check("rearm_busy", busy, 1);
        check("rearm_done", done, 0);
        check("gap_nwr", nwr, exp_writes);
        for (int i = 0; i < 16; i++) seq[i] = 8'($urandom);
        model_run(5, 16);
        drive_seq(16);
        check_run("c2");
        continuous = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("cont_off_done", done, 1);
        check("cont_off_busy", busy, 0);

        // randomized captures from DONE or IDLE
        for (int r = 0; r < 8; r++) begin
            int p;
            mode_sel    = 3'($urandom_range(0, 7));
            channel_sel = 3'($urandom_range(0, 7));
            pattern     = 8'($urandom);
            pat_mask    = 8'($urandom & $urandom);
            p           = $urandom_range(0, 15);
            pre_len     = 4'(p);
            for (int i = 0; i < 40; i++) seq[i] = 8'($urandom);
            model_run(p, 40);
            pulse_arm();
            drive_seq(40);
            tick();
            check_run("rnd");
            if (!exp_done) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("rnd_abort_busy", busy, 0);
            end
        end

        // asynchronous reset during a PREFILL write cycle
        mode_sel = 3'd6; pre_len = 4'd10;
        pulse_arm();
        for (int i = 0; i < 3; i++) seq[i] = 8'($urandom);
        drive_seq(3);
        data_in = 8'h77; clken = 1'b1;
        tick();
        clken = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("arst_wren", wren, 0);
        check("arst_wa", wr_addr, 0);
        check("arst_wdata", wr_data, 0);
        check("arst_busy", busy, 0);
        check("arst_trig", trig_addr, 0);
        check("arst_start", start_addr, 0);
        tick();
        rst = 1'b0;
        exp_wa = 0; exp_trig = 0; exp_start = 0; last_smp = 8'h00;
        tick();

        // capture after reset starts from address 0 again
        mode_sel = 3'd1; channel_sel = 3'd7; pre_len = 4'd6;
        for (int i = 0; i < 30; i++) seq[i] = (i < 12) ? 8'h00 : 8'($urandom) | 8'h80;
        model_run(6, 30);
        pulse_arm();
        drive_seq(30);
        tick();
        check_run("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
